div_sched: RTL and testbench

Round-robin scheduler that shares the single 32-bit Q24.8 fixed-point divider (`div_fp32bit`) among `NREQ` HDR pipeline requesters, e.g. the per-channel weight-normalisation stages. It accepts operand pairs from requesters and issues exactly one division at a time. It captures the divider result, overflow and invalid flags, and returns them to the originating requester with a one-cycle response pulse. It sits between the requesters and the divider, and owns all of the divider's handshake signals.

---
 rtl/div_sched_pkg.sv | 16 +
 rtl/rr_picker.sv | 30 +++
 rtl/div_sched.sv | 121 ++++++++++++
 tb/tb_div_sched.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_sched_pkg.sv
// Shared types and constants for the divider scheduler and the
// Q24.8 divider wrapper.
package div_sched_pkg;

    localparam int N  = 32;
    localparam int FP = 8;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        BUSY,
        DONE,
        RESP
    } state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin priority search: first active request at or after ptr,
// wrapping modulo NREQ.
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    always_comb begin
        logic           found;
        logic [IDW-1:0] idx;
        found     = 1'b0;
        idx       = '0;
        grant     = '0;
        grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/div_sched.sv
// Shares one Q24.8 divider among NREQ requesters, one division at a
// time, returning each result to its owner with a one-cycle pulse.
module div_sched
    import div_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int N    = div_sched_pkg::N,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [N-1:0]      rsp_data,
    output logic              rsp_ovf,
    output logic              rsp_inv,
    output logic [IDW-1:0]    rsp_id,
    output logic [N-1:0]      div_a,
    output logic [N-1:0]      div_b,
    output logic              div_valid,
    input  logic [N-1:0]      div_out,
    input  logic              div_ovf,
    input  logic              div_inv,
    input  logic              div_ready
);

    state_t         state, state_nx;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] owner;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0] g_idx;
    logic           grant_en;
    logic           cap_en;

    logic [N-1:0] a_arr [NREQ];
    logic [N-1:0] b_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_split
        assign a_arr[i] = req_a[i*N +: N];
        assign b_arr[i] = req_b[i*N +: N];
    end

    rr_picker #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_valid (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (g_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        grant_en = 1'b0;
        cap_en   = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid && div_ready) begin
                    grant_en = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: state_nx = BUSY;
            // BUSY spans the start pulse and ends once the divider drops ready
            BUSY: begin
                if (!div_ready) state_nx = DONE;
            end
            DONE: begin
                if (div_ready) begin
                    cap_en   = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            owner     <= '0;
            req_ready <= '0;
            rsp_valid <= '0;
            div_valid <= 1'b0;
            div_a     <= '0;
            div_b     <= '0;
            rsp_data  <= '0;
            rsp_ovf   <= 1'b0;
            rsp_inv   <= 1'b0;
            rsp_id    <= '0;
        end else begin
            req_ready <= grant_en ? grant : '0;
            div_valid <= (state == ISSUE);
            rsp_valid <= '0;
            if (grant_en) begin
                div_a <= a_arr[g_idx];
                div_b <= b_arr[g_idx];
                owner <= g_idx;
                ptr   <= (g_idx == IDW'(NREQ - 1)) ? '0 : g_idx + 1'b1;
            end
            if (cap_en) begin
                rsp_data  <= div_out;
                rsp_ovf   <= div_ovf;
                rsp_inv   <= div_inv;
                rsp_id    <= owner;
                rsp_valid <= NREQ'(1) << owner;
            end
        end
    end

endmodule

// File: tb/tb_div_sched.sv
// Scoreboard bench for div_sched with a behavioural Q24.8 divider.
module tb_div_sched;

    localparam int NREQ = 4;
    localparam int N    = 32;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [N-1:0]      rsp_data;
    logic              rsp_ovf;
    logic              rsp_inv;
    logic [IDW-1:0]    rsp_id;
    logic [N-1:0]      div_a;
    logic [N-1:0]      div_b;
    logic              div_valid;
    logic [N-1:0]      div_out;
    logic              div_ovf;
    logic              div_inv;
    logic              div_ready;

    div_sched #(
        .NREQ (NREQ),
        .N    (N),
        .IDW  (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ovf   (rsp_ovf),
        .rsp_inv   (rsp_inv),
        .rsp_id    (rsp_id),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_valid (div_valid),
        .div_out   (div_out),
        .div_ovf   (div_ovf),
        .div_inv   (div_inv),
        .div_ready (div_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [N-1:0]   data;
        logic           ovf;
        logic           inv;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural divider: result appears lat_cfg cycles after start
    int         lat_cfg = 3;
    int         cnt;
    logic       hold = 1'b0;

    function automatic logic [33:0] div_model(input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] q;
        if (b == 32'd0) return {1'b0, 1'b1, 32'hFFFF_FFFF};
        q = {24'd0, a, 8'd0} / {32'd0, b};
        return {|q[63:32], 1'b0, q[31:0]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= 0;
            div_out <= '0;
            div_ovf <= 1'b0;
            div_inv <= 1'b0;
        end else if (div_valid && div_ready) begin
            cnt <= lat_cfg;
            {div_ovf, div_inv, div_out} <= div_model(div_a, div_b);
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
        end
    end

    assign div_ready = (cnt == 0) && !hold;

    // Monitor: every response pulse pops the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst && rsp_valid != '0) begin
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rsp_valid 0x%0h, expected none",
                         rsp_valid);
            end else begin
                e = sbq.pop_front();
                check("rsp_id", 64'(rsp_id), 64'(e.id));
                check("rsp_onehot", 64'(rsp_valid), 64'(4'b1 << e.id));
                check("rsp_data", 64'(rsp_data), 64'(e.data));
                check("rsp_ovf", 64'(rsp_ovf), 64'(e.ovf));
                check("rsp_inv", 64'(rsp_inv), 64'(e.inv));
            end
        end
    end

    task automatic request(input int i, input logic [31:0] a,
                           input logic [31:0] b, input bit track,
                           input exp_t e);
        bit got;
        got = 1'b0;
        if (track) sbq.push_back(e);
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
        req_valid[i]    = 1'b1;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1'b1;
        end
        req_valid[i] = 1'b0;
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL grant_%0d: req_ready got 0, expected 1", i);
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 300 && sbq.size() != 0; c++) @(negedge clk);
        if (sbq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rsp_timeout: got %0d pending, expected 0", sbq.size());
            sbq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    logic [31:0] fair_a [4] = '{32'd4, 32'd8, 32'd12, 32'd16};
    logic [31:0] fair_q [4] = '{32'h100, 32'h200, 32'h300, 32'h400};

    initial begin
        int   k;
        int   busy_grants;
        exp_t none;
        none      = '0;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_div_valid", 64'(div_valid), 64'd0);
        check("rst_div_ab", {div_a, div_b}, 64'd0);
        check("rst_rsp", 64'({rsp_data, rsp_ovf, rsp_inv, rsp_id}), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Fairness: all four held high for eight divisions
        for (int i = 0; i < 8; i++)
            sbq.push_back('{IDW'(i % 4), fair_q[i % 4], 1'b0, 1'b0});
        for (int i = 0; i < 4; i++) begin
            req_a[i*N +: N] = fair_a[i];
            req_b[i*N +: N] = 32'd4;
        end
        req_valid = '1;
        k = 0;
        for (int c = 0; c < 400 && k < 8; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                check($sformatf("grant_order%0d", k), 64'(req_ready),
                      64'(4'b1 << (k % 4)));
                k++;
            end
        end
        req_valid = '0;
        check("fair_grants", 64'(k), 64'd8);
        drain();

        request(0, 32'd10, 32'd4, 1'b1, '{2'd0, 32'h280, 1'b0, 1'b0});
        drain();
        request(2, 32'd7, 32'd0, 1'b1, '{2'd2, 32'hFFFF_FFFF, 1'b0, 1'b1});
        drain();
        request(1, 32'h8000_0000, 32'd1, 1'b1, '{2'd1, 32'h0, 1'b1, 1'b0});
        drain();

        // Reset while the scheduler waits in DONE on a slow divide
        lat_cfg = 10;
        request(3, 32'd1, 32'd1, 1'b0, none);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_handshake", 64'({req_ready, rsp_valid, div_valid}), 64'd0);
        check("mid_rst_div_ab", {div_a, div_b}, 64'd0);
        check("mid_rst_rsp", 64'({rsp_data, rsp_ovf, rsp_inv, rsp_id}), 64'd0);
        repeat (3) @(negedge clk);
        rst     = 1'b0;
        lat_cfg = 3;
        repeat (20) @(negedge clk);
        request(1, 32'd3, 32'd2, 1'b1, '{2'd1, 32'h180, 1'b0, 1'b0});
        drain();

        // Back-pressure: divider held not-ready with req 3 pending
        hold = 1'b1;
        sbq.push_back('{2'd3, 32'h300, 1'b0, 1'b0});
        req_a[3*N +: N] = 32'd9;
        req_b[3*N +: N] = 32'd3;
        req_valid[3]    = 1'b1;
        busy_grants     = 0;
        repeat (5) begin
            @(negedge clk);
            if (req_ready != '0) busy_grants++;
        end
        check("bp_no_grant", 64'(busy_grants), 64'd0);
        hold = 1'b0;
        @(negedge clk);
        check("bp_grant", 64'(req_ready), 64'h8);
        req_valid[3] = 1'b0;
        @(negedge clk);
        check("bp_div_valid", 64'({div_valid, req_ready}), 64'h10);
        drain();

        check("sb_empty", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
